// File: rtl/heai_clk_pkg.sv
// Shared clocking definitions for consumers of the 20.625 MHz iCE40 PLL output:
// NCO state encoding, PLL frequency, default accumulator width and an increment helper.
package heai_clk_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int unsigned PLL_HZ        = 32'd20_625_000;
    localparam int unsigned ACC_W_DEFAULT = 32'd32;

    // Increment giving target_hz ticks from a 32-bit accumulator clocked at PLL_HZ.
    function automatic logic [31:0] calc_inc(input logic [31:0] target_hz);
        logic [63:0] w_scaled;
        w_scaled = ({32'd0, target_hz} << 6'd32) / 64'(PLL_HZ);
        return w_scaled[31:0];
    endfunction

endpackage

// File: rtl/nco_tick_gen_settle_timer.sv
// settle_timer: HOLDOFF-cycle down-counter restarted by reset; done stays high once expired.
// Reusable by any PLL consumer that must ignore the clock while the PLL locks.
module settle_timer #(
    parameter int unsigned HOLDOFF = 32'd1024
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam int unsigned CNT_W = (HOLDOFF > 32'd1) ? $clog2(HOLDOFF) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HOLDOFF - 32'd1);

    logic [CNT_W-1:0] r_cnt;

    // Count down to zero after reset, then hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= CNT_INIT;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign done = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/nco_tick_gen.sv
// Phase-accumulator NCO producing a single-cycle tick enable after a PLL settle interval.
// Optional tick counter is enabled by defining NCO_TICK_COUNT_EN.
module nco_tick_gen
    import heai_clk_pkg::*;
#(
    parameter int unsigned      ACC_W     = ACC_W_DEFAULT,
    parameter int unsigned      HOLDOFF   = 32'd1024,
    parameter logic [ACC_W-1:0] INC_RESET = {ACC_W{1'b0}}
) (
    input  logic             pll_clock,
    input  logic             reset,
    input  logic [ACC_W-1:0] inc_data,
    input  logic             inc_valid,
    output logic             inc_ready,
    output logic             tick,
    output logic             running,
    output logic [7:0]       phase
`ifdef NCO_TICK_COUNT_EN
    ,
    input  logic             tick_count_clr,
    output logic [15:0]      tick_count
`endif
);

    state_e           r_state;
    state_e           w_next_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc_active;
    logic [ACC_W-1:0] r_pending;
    logic             r_pending_valid;
    logic             r_tick;
    logic             r_running;
    logic             r_inc_ready;
    logic [ACC_W:0]   w_sum;
    logic             w_carry;
    logic             w_accept;
    logic             w_apply;
    logic             w_hold_done;

    settle_timer #(
        .HOLDOFF (HOLDOFF)
    ) u_settle (
        .clk   (pll_clock),
        .reset (reset),
        .done  (w_hold_done)
    );

    assign w_sum    = {1'b0, r_acc} + {1'b0, r_inc_active};
    assign w_carry  = w_sum[ACC_W];
    assign w_accept = inc_valid && r_inc_ready;

    // Next-state and increment-apply decision.
    always_comb begin
        w_next_state = r_state;
        w_apply      = 1'b0;
        case (r_state)
            HOLD: begin
                if (w_hold_done) begin
                    w_next_state = (r_inc_active != {ACC_W{1'b0}}) ? RUN : IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            RUN: begin
                // A new rate only lands on a wrapping add so no period is truncated.
                if (w_carry && r_pending_valid) begin
                    w_apply      = 1'b1;
                    w_next_state = (r_pending != {ACC_W{1'b0}}) ? RUN : IDLE;
                end else begin
                    w_next_state = RUN;
                end
            end
            IDLE: begin
                if (r_pending_valid) begin
                    w_apply      = 1'b1;
                    w_next_state = (r_pending != {ACC_W{1'b0}}) ? RUN : IDLE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = HOLD;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Accumulator, handshake slot and registered outputs.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            r_acc           <= {ACC_W{1'b0}};
            r_inc_active    <= INC_RESET;
            r_pending       <= {ACC_W{1'b0}};
            r_pending_valid <= 1'b0;
            r_tick          <= 1'b0;
            r_running       <= 1'b0;
            r_inc_ready     <= 1'b1;
        end else begin
            if (r_state == RUN) begin
                r_acc  <= w_sum[ACC_W-1:0];
                r_tick <= w_carry;
            end else begin
                r_acc  <= r_acc;
                r_tick <= 1'b0;
            end
            if (w_apply) begin
                r_inc_active <= r_pending;
            end else begin
                r_inc_active <= r_inc_active;
            end
            if (w_accept) begin
                r_pending       <= inc_data;
                r_pending_valid <= 1'b1;
                r_inc_ready     <= 1'b0;
            end else if (w_apply) begin
                r_pending       <= r_pending;
                r_pending_valid <= 1'b0;
                r_inc_ready     <= 1'b1;
            end else begin
                r_pending       <= r_pending;
                r_pending_valid <= r_pending_valid;
                r_inc_ready     <= r_inc_ready;
            end
            r_running <= (w_next_state == RUN);
        end
    end

    assign inc_ready = r_inc_ready;
    assign tick      = r_tick;
    assign running   = r_running;
    assign phase     = r_acc[ACC_W-1 -: 8];

`ifdef NCO_TICK_COUNT_EN
    logic [15:0] r_tick_count;

    // Wrapping tick counter; clear wins over a coincident tick.
    always_ff @(posedge pll_clock) begin
        if (reset) begin
            r_tick_count <= 16'd0;
        end else if (tick_count_clr) begin
            r_tick_count <= 16'd0;
        end else if (r_tick) begin
            r_tick_count <= r_tick_count + 16'd1;
        end else begin
            r_tick_count <= r_tick_count;
        end
    end

    assign tick_count = r_tick_count;
`endif

endmodule

// File: tb/tb_nco_tick_gen.sv
// Scoreboard bench for nco_tick_gen (ACC_W=8, HOLDOFF=4, INC_RESET=64): directed test-plan
// sequences then random traffic, checked against a cycle-level arithmetic reference model.
module tb_nco_tick_gen;

    localparam int AW  = 8;
    localparam int HO  = 4;
    localparam int IR  = 64;
    localparam int MOD = 256;
    localparam int M_HOLD = 0;
    localparam int M_IDLE = 1;
    localparam int M_RUN  = 2;

    typedef struct packed {
        logic        tick;
        logic        running;
        logic [7:0]  phase;
        logic        ready;
        logic [15:0] tcnt;
    } exp_t;

    logic        pll_clock = 1'b0;
    logic        reset     = 1'b1;
    logic [7:0]  inc_data  = 8'd0;
    logic        inc_valid = 1'b0;
    logic        inc_ready;
    logic        tick;
    logic        running;
    logic [7:0]  phase;
`ifdef NCO_TICK_COUNT_EN
    logic        tick_count_clr = 1'b0;
    logic [15:0] tick_count;
`endif

    nco_tick_gen #(
        .ACC_W     (32'd8),
        .HOLDOFF   (32'd4),
        .INC_RESET (8'd64)
    ) dut (
        .pll_clock (pll_clock),
        .reset     (reset),
        .inc_data  (inc_data),
        .inc_valid (inc_valid),
        .inc_ready (inc_ready),
        .tick      (tick),
        .running   (running),
        .phase     (phase)
`ifdef NCO_TICK_COUNT_EN
        ,
        .tick_count_clr (tick_count_clr),
        .tick_count     (tick_count)
`endif
    );

    always #5 pll_clock = ~pll_clock;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    // Reference model: behaviour described as elapsed settle time, mode and modular sums.
    int m_mode, m_elapsed, m_acc, m_inc, m_pend, m_pend_v, m_tick, m_tcnt;

    task automatic model_step(input bit rst, input bit v, input int d, input bit clr);
        int  s;
        int  nmode;
        bit  carry;
        bit  take;
        bit  apply;
        if (rst) begin
            m_mode = M_HOLD; m_elapsed = 0; m_acc = 0; m_inc = IR;
            m_pend = 0; m_pend_v = 0; m_tick = 0; m_tcnt = 0;
        end else begin
            take  = v && (m_pend_v == 0);
            carry = 1'b0;
            apply = 1'b0;
            nmode = m_mode;
            if (m_mode == M_HOLD) begin
                m_elapsed++;
                if (m_elapsed >= HO) nmode = (m_inc != 0) ? M_RUN : M_IDLE;
            end else if (m_mode == M_RUN) begin
                s     = m_acc + m_inc;
                carry = (s >= MOD);
                m_acc = s % MOD;
                apply = carry && (m_pend_v != 0);
            end else begin
                apply = (m_pend_v != 0);
            end
            if (apply) begin
                m_inc    = m_pend;
                m_pend_v = 0;
                nmode    = (m_inc != 0) ? M_RUN : M_IDLE;
            end
            if (take) begin
                m_pend   = d;
                m_pend_v = 1;
            end
            m_tcnt = clr ? 0 : (m_tcnt + m_tick) % 65536;
            m_tick = carry ? 1 : 0;
            m_mode = nmode;
        end
    endtask

    // Drive one cycle of inputs, push the predicted post-edge outputs, advance one clock.
    task automatic step(input bit rst, input bit v, input logic [7:0] d, input bit clr);
        exp_t e;
        reset     = rst;
        inc_valid = v;
        inc_data  = d;
`ifdef NCO_TICK_COUNT_EN
        tick_count_clr = clr;
`endif
        model_step(rst, v, int'(d), clr);
        e.tick    = (m_tick != 0);
        e.running = (m_mode == M_RUN);
        e.phase   = 8'(m_acc);
        e.ready   = (m_pend_v == 0);
`ifdef NCO_TICK_COUNT_EN
        e.tcnt    = 16'(m_tcnt);
`else
        e.tcnt    = 16'd0;
`endif
        sb_q.push_back(e);
        @(posedge pll_clock);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare against the queue head.
    exp_t mon_e;
    exp_t mon_a;
    always @(negedge pll_clock) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a.tick    = tick;
            mon_a.running = running;
            mon_a.phase   = phase;
            mon_a.ready   = inc_ready;
`ifdef NCO_TICK_COUNT_EN
            mon_a.tcnt    = tick_count;
`else
            mon_a.tcnt    = 16'd0;
`endif
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_err++;
                $display("FAIL outputs t=%0t got tick=%b run=%b phase=%h rdy=%b cnt=%0d exp tick=%b run=%b phase=%h rdy=%b cnt=%0d",
                         $time, mon_a.tick, mon_a.running, mon_a.phase, mon_a.ready, mon_a.tcnt,
                         mon_e.tick, mon_e.running, mon_e.phase, mon_e.ready, mon_e.tcnt);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int         n_ticks;
        int         sel;
        logic [7:0] d;
        bit         r;
        bit         v;
        bit         c;

        // Reset, then settle and run at the reset increment.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'd0, 1'b0);

        // Mid-period rate change at acc == 0x40.
        for (int i = 0; i < 16 && !(m_mode == M_RUN && m_acc == 8'h40); i++)
            step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'd128, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd0, 1'b0);

        // Stop with 0, then restart at 0xFF and count ticks over a 256-cycle window.
        step(1'b0, 1'b1, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'hFF, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'd0, 1'b0);
        n_ticks = 0;
        for (int i = 0; i < 256; i++) begin
            step(1'b0, 1'b0, 8'd0, 1'b0);
            if (tick === 1'b1) n_ticks++;
        end
        n_cmp++;
        if (n_ticks != 255) begin
            n_err++;
            $display("FAIL ff_rate got %0d ticks, need 255 per 256 cycles", n_ticks);
        end

        // Backpressure: second back-to-back valid is refused.
        step(1'b0, 1'b1, 8'd64, 1'b0);
        step(1'b0, 1'b1, 8'd1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'd0, 1'b0);

        // Reset mid-RUN with a value pending.
        step(1'b0, 1'b1, 8'd128, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'd0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 7) == 0);
            c   = ($urandom_range(0, 15) == 0);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       d = 8'd0;
                1:       d = 8'd1;
                2:       d = 8'd64;
                3:       d = 8'd128;
                4:       d = 8'hFF;
                default: d = 8'($urandom_range(0, 255));
            endcase
            step(r, v, d, c);
        end

        step(1'b0, 1'b0, 8'd0, 1'b0);
        @(negedge pll_clock);
        @(negedge pll_clock);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain got %0d outstanding, need 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
